// File: rtl/mult_pipe_multichannel.sv
// Multi-lane pipelined multiplier with valid strobe, stall enable, signed/unsigned
// mode, truncate/round scaling with saturation and optional redundant-sign drop.
module mult_pipe_multichannel #(
  parameter int A_WIDTH     = 12,
  parameter int B_WIDTH     = 12,
  parameter int CHANNELS    = 2,
  parameter int PIPE_STAGES = 3,
  parameter int OUT_WIDTH   = 24,
  parameter int SIGNED      = 1,
  parameter int DROP_SIGN   = 0
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          ClkEn,
  input  logic                          InValid,
  input  logic                          RoundEn,
  input  logic [CHANNELS*A_WIDTH-1:0]   DataA,
  input  logic [CHANNELS*B_WIDTH-1:0]   DataB,
  output logic                          OutValid,
  output logic [CHANNELS*OUT_WIDTH-1:0] Result,
  output logic [CHANNELS-1:0]           Sat
);

  localparam int FULL    = A_WIDTH + B_WIDTH;
  localparam int DROP    = (SIGNED != 0 && DROP_SIGN != 0) ? 1 : 0;
  localparam int P       = FULL - DROP;
  localparam int D       = P - OUT_WIDTH;
  localparam int W       = FULL + 1 - D;
  localparam int RND_BIT = (D > 0) ? D - 1 : 0;
  localparam logic           SGN     = (SIGNED != 0);
  localparam logic [FULL:0]  RND_INC = (D > 0) ? ((FULL+1)'(1) << RND_BIT) : '0;

  // Both operands are extended to the full product width, so one modular
  // multiply gives the correct product in signed and unsigned mode alike.
  function automatic logic [FULL-1:0] mul_lane(input logic [A_WIDTH-1:0] a,
                                               input logic [B_WIDTH-1:0] b);
    logic [FULL-1:0] ea;
    logic [FULL-1:0] eb;
    ea = {{B_WIDTH{SGN & a[A_WIDTH-1]}}, a};
    eb = {{A_WIDTH{SGN & b[B_WIDTH-1]}}, b};
    return ea * eb;
  endfunction

  // Returns {sat, result}. One guard bit above the product absorbs the
  // rounding carry; dropping the low D bits of two's complement is a floor.
  function automatic logic [OUT_WIDTH:0] scale_lane(input logic [FULL-1:0] p,
                                                    input logic            rnd);
    logic [FULL:0]          sum;
    logic [W-1:0]           v;
    logic                   fits;
    logic [OUT_WIDTH-1:0]   res;
    sum = {SGN & p[FULL-1], p} + (rnd ? RND_INC : '0);
    v   = sum[FULL:D];
    if (SGN) begin
      fits = (&v[W-1:OUT_WIDTH-1]) | ~(|v[W-1:OUT_WIDTH-1]);
    end else begin
      fits = ~(|v[W-1:OUT_WIDTH]);
    end
    res = v[OUT_WIDTH-1:0];
    if (!fits) begin
      if (SGN) begin
        res = v[W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end else begin
        res = '1;
      end
    end
    return {~fits, res};
  endfunction

  // Stage 1: operand and control capture
  logic [CHANNELS*A_WIDTH-1:0] a_d, a_q;
  logic [CHANNELS*B_WIDTH-1:0] b_d, b_q;
  logic                        vld1_d, vld1_q;
  logic                        rnd1_d, rnd1_q;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    vld1_d = vld1_q;
    rnd1_d = rnd1_q;
    if (ClkEn) begin
      a_d    = DataA;
      b_d    = DataB;
      vld1_d = InValid;
      rnd1_d = RoundEn;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_q    <= '0;
      b_q    <= '0;
      vld1_q <= 1'b0;
      rnd1_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      vld1_q <= vld1_d;
      rnd1_q <= rnd1_d;
    end
  end

  logic [CHANNELS*FULL-1:0] prod_c;

  always_comb begin
    prod_c = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      prod_c[ch*FULL +: FULL] = mul_lane(a_q[ch*A_WIDTH +: A_WIDTH], b_q[ch*B_WIDTH +: B_WIDTH]);
    end
  end

  logic [CHANNELS*FULL-1:0] fin_prod;
  logic                     fin_vld;
  logic                     fin_rnd;

  // Middle stages carry the full product; with two stages the multiply feeds
  // the output stage directly.
  if (PIPE_STAGES > 2) begin : g_mid
    localparam int NM = PIPE_STAGES - 2;
    logic [NM-1:0][CHANNELS*FULL-1:0] prod_d, prod_q;
    logic [NM-1:0]                    vld_d, vld_q;
    logic [NM-1:0]                    rnd_d, rnd_q;

    always_comb begin
      prod_d = prod_q;
      vld_d  = vld_q;
      rnd_d  = rnd_q;
      if (ClkEn) begin
        prod_d[0] = prod_c;
        vld_d[0]  = vld1_q;
        rnd_d[0]  = rnd1_q;
        for (int unsigned i = 1; i < NM; i++) begin
          prod_d[i] = prod_q[i-1];
          vld_d[i]  = vld_q[i-1];
          rnd_d[i]  = rnd_q[i-1];
        end
      end
    end

    always_ff @(posedge Clock) begin
      if (Reset) begin
        prod_q <= '0;
        vld_q  <= '0;
        rnd_q  <= '0;
      end else begin
        prod_q <= prod_d;
        vld_q  <= vld_d;
        rnd_q  <= rnd_d;
      end
    end

    assign fin_prod = prod_q[NM-1];
    assign fin_vld  = vld_q[NM-1];
    assign fin_rnd  = rnd_q[NM-1];
  end else begin : g_direct
    assign fin_prod = prod_c;
    assign fin_vld  = vld1_q;
    assign fin_rnd  = rnd1_q;
  end

  // Output stage: Result/Sat only load with a valid sample
  logic                          out_valid_d, out_valid_q;
  logic [CHANNELS*OUT_WIDTH-1:0] result_d, result_q;
  logic [CHANNELS-1:0]           sat_d, sat_q;

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    sat_d       = sat_q;
    if (ClkEn) begin
      out_valid_d = fin_vld;
      if (fin_vld) begin
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
          {sat_d[ch], result_d[ch*OUT_WIDTH +: OUT_WIDTH]} =
            scale_lane(fin_prod[ch*FULL +: FULL], fin_rnd);
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      sat_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      sat_q       <= sat_d;
    end
  end

  assign OutValid = out_valid_q;
  assign Result   = result_q;
  assign Sat      = sat_q;

endmodule

// File: tb/tb_mult_pipe_multichannel.sv
module tb_mult_pipe_multichannel;

  localparam int NI = 4;
  localparam int OW0 = 24, OW1 = 16, OW2 = 16, OW3 = 20;
  localparam int PS0 = 3,  PS1 = 2,  PS2 = 5,  PS3 = 4;
  localparam int SG0 = 1,  SG1 = 1,  SG2 = 1,  SG3 = 0;
  localparam int DS0 = 0,  DS1 = 0,  DS2 = 1,  DS3 = 0;
  localparam int OW [NI] = '{OW0, OW1, OW2, OW3};
  localparam int PS [NI] = '{PS0, PS1, PS2, PS3};
  localparam int SG [NI] = '{SG0, SG1, SG2, SG3};
  localparam int DS [NI] = '{DS0, DS1, DS2, DS3};

  logic        Clock = 1'b0;
  logic        Reset, ClkEn, InValid, RoundEn;
  logic [23:0] DataA, DataB;

  logic        ov0, ov1, ov2, ov3;
  logic [47:0] res0;
  logic [31:0] res1, res2;
  logic [39:0] res3;
  logic [1:0]  sat0, sat1, sat2, sat3;

  always #5 Clock = ~Clock;

  mult_pipe_multichannel #(.A_WIDTH(12), .B_WIDTH(12), .CHANNELS(2), .PIPE_STAGES(PS0),
    .OUT_WIDTH(OW0), .SIGNED(SG0), .DROP_SIGN(DS0)) u_dut0 (
    .Clock(Clock), .Reset(Reset), .ClkEn(ClkEn), .InValid(InValid), .RoundEn(RoundEn),
    .DataA(DataA), .DataB(DataB), .OutValid(ov0), .Result(res0), .Sat(sat0));

  mult_pipe_multichannel #(.A_WIDTH(12), .B_WIDTH(12), .CHANNELS(2), .PIPE_STAGES(PS1),
    .OUT_WIDTH(OW1), .SIGNED(SG1), .DROP_SIGN(DS1)) u_dut1 (
    .Clock(Clock), .Reset(Reset), .ClkEn(ClkEn), .InValid(InValid), .RoundEn(RoundEn),
    .DataA(DataA), .DataB(DataB), .OutValid(ov1), .Result(res1), .Sat(sat1));

  mult_pipe_multichannel #(.A_WIDTH(12), .B_WIDTH(12), .CHANNELS(2), .PIPE_STAGES(PS2),
    .OUT_WIDTH(OW2), .SIGNED(SG2), .DROP_SIGN(DS2)) u_dut2 (
    .Clock(Clock), .Reset(Reset), .ClkEn(ClkEn), .InValid(InValid), .RoundEn(RoundEn),
    .DataA(DataA), .DataB(DataB), .OutValid(ov2), .Result(res2), .Sat(sat2));

  mult_pipe_multichannel #(.A_WIDTH(12), .B_WIDTH(12), .CHANNELS(2), .PIPE_STAGES(PS3),
    .OUT_WIDTH(OW3), .SIGNED(SG3), .DROP_SIGN(DS3)) u_dut3 (
    .Clock(Clock), .Reset(Reset), .ClkEn(ClkEn), .InValid(InValid), .RoundEn(RoundEn),
    .DataA(DataA), .DataB(DataB), .OutValid(ov3), .Result(res3), .Sat(sat3));

  logic        act_vld [NI];
  logic [47:0] act_res [NI];
  logic [1:0]  act_sat [NI];
  assign act_vld[0] = ov0;  assign act_res[0] = res0;           assign act_sat[0] = sat0;
  assign act_vld[1] = ov1;  assign act_res[1] = {16'd0, res1};  assign act_sat[1] = sat1;
  assign act_vld[2] = ov2;  assign act_res[2] = {16'd0, res2};  assign act_sat[2] = sat2;
  assign act_vld[3] = ov3;  assign act_res[3] = {8'd0, res3};   assign act_sat[3] = sat3;

  typedef struct {
    longint      due;
    logic [47:0] res;
    logic [1:0]  sat;
  } exp_t;

  exp_t        sb [NI][$];
  longint      en_cnt = 0;
  logic        edge_rst, edge_en;
  logic        m_vld [NI];
  logic [47:0] m_res [NI];
  logic [1:0]  m_sat [NI];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic void model(input int i, input logic rnd, input logic [23:0] a,
                                input logic [23:0] b, output logic [47:0] res,
                                output logic [1:0] sat);
    longint      av, bv, p, v, lo, hi;
    int          d;
    logic [63:0] vb, mask;
    logic [11:0] af, bf;
    res = '0;
    sat = '0;
    d = 24 - ((SG[i] != 0 && DS[i] != 0) ? 1 : 0) - OW[i];
    for (int l = 0; l < 2; l++) begin
      af = a[l*12 +: 12];
      bf = b[l*12 +: 12];
      if (SG[i] != 0) begin
        av = longint'($signed(af));
        bv = longint'($signed(bf));
        lo = -(longint'(1) <<< (OW[i] - 1));
        hi = (longint'(1) <<< (OW[i] - 1)) - 1;
      end else begin
        av = longint'(af);
        bv = longint'(bf);
        lo = 0;
        hi = (longint'(1) <<< OW[i]) - 1;
      end
      p = av * bv;
      if (rnd && d > 0) p = p + (longint'(1) <<< (d - 1));
      v = p >>> d;
      if (v > hi) begin
        v = hi;
        sat[l] = 1'b1;
      end else if (v < lo) begin
        v = lo;
        sat[l] = 1'b1;
      end
      mask = (64'd1 << OW[i]) - 64'd1;
      vb   = 64'(v) & mask;
      res  = res | 48'(vb << (l * OW[i]));
    end
  endfunction

  always @(posedge Clock) begin
    exp_t e;
    edge_rst = Reset;
    edge_en  = ClkEn;
    if (Reset) begin
      for (int i = 0; i < NI; i++) sb[i].delete();
    end else if (ClkEn) begin
      en_cnt = en_cnt + 1;
      if (InValid) begin
        for (int i = 0; i < NI; i++) begin
          model(i, RoundEn, DataA, DataB, e.res, e.sat);
          e.due = en_cnt + longint'(PS[i]) - 1;
          sb[i].push_back(e);
        end
      end
    end
  end

  always @(posedge Clock) begin
    exp_t e;
    #1;
    for (int i = 0; i < NI; i++) begin
      if (edge_rst) begin
        m_vld[i] = 1'b0;
        m_res[i] = '0;
        m_sat[i] = '0;
      end else if (edge_en) begin
        m_vld[i] = 1'b0;
        if (sb[i].size() > 0 && sb[i][0].due == en_cnt) begin
          e = sb[i].pop_front();
          m_vld[i] = 1'b1;
          m_res[i] = e.res;
          m_sat[i] = e.sat;
        end
      end
      n_vec++;
      if (act_vld[i] !== m_vld[i] || act_res[i] !== m_res[i] || act_sat[i] !== m_sat[i]) begin
        n_err++;
        $display("FAIL inst%0d t=%0t: got vld=%b res=%h sat=%b, want vld=%b res=%h sat=%b",
                 i, $time, act_vld[i], act_res[i], act_sat[i], m_vld[i], m_res[i], m_sat[i]);
      end
    end
  end

  task automatic cyc(input logic r, input logic en, input logic v, input logic rd,
                     input logic [11:0] a0, input logic [11:0] b0,
                     input logic [11:0] a1, input logic [11:0] b1);
    Reset   = r;
    ClkEn   = en;
    InValid = v;
    RoundEn = rd;
    DataA   = {a1, a0};
    DataB   = {b1, b0};
    @(negedge Clock);
  endtask

  function automatic logic [11:0] pick();
    case ($urandom_range(0, 5))
      0:       return 12'h800;
      1:       return 12'h7FF;
      2:       return 12'h000;
      3:       return 12'hFFF;
      4:       return 12'h001;
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 12'h0, 12'h0, 12'h0, 12'h0);
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < NI; i++) begin
      n_vec++;
      if (act_vld[i] !== 1'b0 || act_res[i] !== 48'd0 || act_sat[i] !== 2'b00) begin
        n_err++;
        $display("FAIL reset-state %s inst%0d t=%0t: vld=%b res=%h sat=%b",
                 tag, i, $time, act_vld[i], act_res[i], act_sat[i]);
      end
    end
  endtask

  task automatic wait_ov0(input int n, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      idle(1);
      if (ov0 === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL wait expired %s t=%0t: OutValid not seen within %0d clocks", tag, $time, n);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 1'b1, 1'($urandom), 1'($urandom), 12'($urandom), 12'($urandom),
          12'($urandom), 12'($urandom));
      chk_reset("during");
    end
    idle(1);
    chk_reset("after-release");
    idle(1);

    cyc(1'b0, 1'b1, 1'b1, 1'b0, 12'h7FF, 12'h7FF, 12'h800, 12'h800);
    wait_ov0(7, "extreme");

    cyc(1'b0, 1'b1, 1'b1, 1'b0, 12'd1, 12'd1, 12'd5, 12'd6);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 12'd2, 12'd1, 12'd7, 12'd8);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 12'd9, 12'd9, 12'd9, 12'd9);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'd9, 12'd9, 12'd9, 12'd9);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 12'd3, 12'd1, 12'd1, 12'd1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 12'd4, 12'd1, 12'd2, 12'd2);
    idle(7);

    cyc(1'b0, 1'b1, 1'b1, 1'b0, 12'd3,   12'd43, 12'h7FF, 12'h7FF);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 12'd3,   12'd43, 12'h7FF, 12'h7FF);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 12'hFFD, 12'd43, 12'h800, 12'h7FF);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 12'hFFD, 12'd43, 12'h800, 12'h7FF);
    idle(7);

    cyc(1'b0, 1'b1, 1'b1, 1'b1, 12'h800, 12'h800, 12'h7FF, 12'h7FF);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 12'h800, 12'h800, 12'h7FF, 12'h7FF);
    idle(7);

    cyc(1'b0, 1'b1, 1'b1, 1'b0, 12'h123, 12'h045, 12'h0AB, 12'h0CD);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 12'h0,   12'h0,   12'h0,   12'h0);
    idle(1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 12'h456, 12'h789, 12'hF00, 12'h00F);
    wait_ov0(7, "post-reset");

    for (int k = 0; k < 1500; k++)
      cyc(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) < 8),
          1'($urandom_range(0, 9) < 6), 1'($urandom), pick(), pick(), pick(), pick());
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    if (n_err == 0) $display("PASS");
    else            $display("FAIL");
    $finish;
  end

endmodule
